// File: rtl/writeback_arbiter.sv
// Round-robin merge of execute-unit commit streams into one registered writeback stream, locking across sop..eop packets.
// Latency 1 cycle; commit_ready is the one-hot grant, since writeback itself never stalls. Optional WB_ARB_PERF_EN adds a stall-cycle counter.
module writeback_arbiter #(
    parameter int NUM_INPUTS  = 3,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int WIS_W       = 2,
    parameter int PC_BITS     = 30,
    parameter int NR_BITS     = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS-1:0]                commit_valid,
    input  logic [NUM_INPUTS*UUID_WIDTH-1:0]     commit_uuid,
    input  logic [NUM_INPUTS*WIS_W-1:0]          commit_wis,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0]    commit_tmask,
    input  logic [NUM_INPUTS*PC_BITS-1:0]        commit_PC,
    input  logic [NUM_INPUTS*NR_BITS-1:0]        commit_rd,
    input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] commit_data,
    input  logic [NUM_INPUTS-1:0]                commit_sop,
    input  logic [NUM_INPUTS-1:0]                commit_eop,
    output logic [NUM_INPUTS-1:0]                commit_ready,
    output logic                                 writeback_valid,
    output logic [UUID_WIDTH-1:0]                writeback_uuid,
    output logic [WIS_W-1:0]                     writeback_wis,
    output logic [NUM_THREADS-1:0]               writeback_tmask,
    output logic [PC_BITS-1:0]                   writeback_PC,
    output logic [NR_BITS-1:0]                   writeback_rd,
    output logic [NUM_THREADS*XLEN-1:0]          writeback_data,
    output logic                                 writeback_sop,
    output logic                                 writeback_eop
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                          perf_stall_cycles
`endif
);
    localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DW    = NUM_THREADS * XLEN;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W:0]        rr_sum;
    logic [NUM_INPUTS-1:0] grant;
    logic                  xfer;
    logic                  win_eop;

    logic                  wb_valid_q;
    logic [UUID_WIDTH-1:0] wb_uuid_q;
    logic [WIS_W-1:0]      wb_wis_q;
    logic [NUM_THREADS-1:0] wb_tmask_q;
    logic [PC_BITS-1:0]    wb_pc_q;
    logic [NR_BITS-1:0]    wb_rd_q;
    logic [DW-1:0]         wb_data_q;
    logic                  wb_sop_q;
    logic                  wb_eop_q;

    // Scan from the highest offset down so the last hit is the first valid input at or after the pointer.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        rr_sum  = '0;
        if (state_q == LOCKED) begin
            win_idx        = owner_q;
            grant[owner_q] = commit_valid[owner_q];
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                rr_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
                if (rr_sum >= (PTR_W + 1)'(NUM_INPUTS)) begin
                    rr_sum = rr_sum - (PTR_W + 1)'(NUM_INPUTS);
                end
                if (commit_valid[rr_sum[PTR_W-1:0]]) begin
                    grant                    = '0;
                    grant[rr_sum[PTR_W-1:0]] = 1'b1;
                    win_idx                  = rr_sum[PTR_W-1:0];
                end
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    assign commit_ready = grant;
    assign xfer         = |grant;
    assign win_eop      = commit_eop[win_idx];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (win_eop) begin
                state_d = UNLOCKED;
                ptr_d   = (win_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_d = LOCKED;
                owner_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Fields hold their last value on idle cycles; only valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_uuid_q  <= '0;
            wb_wis_q   <= '0;
            wb_tmask_q <= '0;
            wb_pc_q    <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_sop_q   <= 1'b0;
            wb_eop_q   <= 1'b0;
        end else begin
            wb_valid_q <= xfer;
            if (xfer) begin
                wb_uuid_q  <= commit_uuid[win_idx*UUID_WIDTH +: UUID_WIDTH];
                wb_wis_q   <= commit_wis[win_idx*WIS_W +: WIS_W];
                wb_tmask_q <= commit_tmask[win_idx*NUM_THREADS +: NUM_THREADS];
                wb_pc_q    <= commit_PC[win_idx*PC_BITS +: PC_BITS];
                wb_rd_q    <= commit_rd[win_idx*NR_BITS +: NR_BITS];
                wb_data_q  <= commit_data[win_idx*DW +: DW];
                wb_sop_q   <= commit_sop[win_idx];
                wb_eop_q   <= win_eop;
            end
        end
    end

    assign writeback_valid = wb_valid_q;
    assign writeback_uuid  = wb_uuid_q;
    assign writeback_wis   = wb_wis_q;
    assign writeback_tmask = wb_tmask_q;
    assign writeback_PC    = wb_pc_q;
    assign writeback_rd    = wb_rd_q;
    assign writeback_data  = wb_data_q;
    assign writeback_sop   = wb_sop_q;
    assign writeback_eop   = wb_eop_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (|(commit_valid & ~commit_ready)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a stimulus table pushes expected beats into a scoreboard; a monitor pops and compares each writeback beat.
module tb_writeback_arbiter;
    localparam int N  = 3;
    localparam int NT = 4;
    localparam int XL = 32;

    typedef struct packed {
        logic [0:0]      uuid;
        logic [1:0]      wis;
        logic [3:0]      tmask;
        logic [29:0]     pc;
        logic [5:0]      rd;
        logic [NT*XL-1:0] data;
        logic            sop;
        logic            eop;
    } beat_t;

    logic               clk;
    logic               reset;
    logic [N-1:0]       commit_valid;
    logic [N-1:0]       commit_uuid;
    logic [N*2-1:0]     commit_wis;
    logic [N*NT-1:0]    commit_tmask;
    logic [N*30-1:0]    commit_PC;
    logic [N*6-1:0]     commit_rd;
    logic [N*NT*XL-1:0] commit_data;
    logic [N-1:0]       commit_sop;
    logic [N-1:0]       commit_eop;
    logic [N-1:0]       commit_ready;
    logic               writeback_valid;
    logic [0:0]         writeback_uuid;
    logic [1:0]         writeback_wis;
    logic [3:0]         writeback_tmask;
    logic [29:0]        writeback_PC;
    logic [5:0]         writeback_rd;
    logic [NT*XL-1:0]   writeback_data;
    logic               writeback_sop;
    logic               writeback_eop;
`ifdef WB_ARB_PERF_EN
    logic [31:0]        perf_stall_cycles;
`endif

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t cur_b[N];
    logic  prev_vld = 1'b0;

    writeback_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_uuid     (commit_uuid),
        .commit_wis      (commit_wis),
        .commit_tmask    (commit_tmask),
        .commit_PC       (commit_PC),
        .commit_rd       (commit_rd),
        .commit_data     (commit_data),
        .commit_sop      (commit_sop),
        .commit_eop      (commit_eop),
        .commit_ready    (commit_ready),
        .writeback_valid (writeback_valid),
        .writeback_uuid  (writeback_uuid),
        .writeback_wis   (writeback_wis),
        .writeback_tmask (writeback_tmask),
        .writeback_PC    (writeback_PC),
        .writeback_rd    (writeback_rd),
        .writeback_data  (writeback_data),
        .writeback_sop   (writeback_sop),
        .writeback_eop   (writeback_eop)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk_beat(input int i, input logic [5:0] rd, input logic s, input logic e);
        beat_t b;
        b.uuid  = 1'(i);
        b.wis   = 2'(i);
        b.tmask = 4'(i + 1);
        b.pc    = 30'(32'h100 * i + 32'(rd));
        b.rd    = rd;
        for (int l = 0; l < NT; l++) begin
            b.data[l*XL +: XL] = {8'(i), 2'b00, rd, 8'(l), 8'hA5};
        end
        b.sop = s;
        b.eop = e;
        return b;
    endfunction

    task automatic set_in(input int i, input logic v, input logic [5:0] rd, input logic s, input logic e);
        beat_t b;
        b = mk_beat(i, rd, s, e);
        commit_valid[i]            = v;
        commit_uuid[i]             = b.uuid;
        commit_wis[i*2 +: 2]       = b.wis;
        commit_tmask[i*NT +: NT]   = b.tmask;
        commit_PC[i*30 +: 30]      = b.pc;
        commit_rd[i*6 +: 6]        = b.rd;
        commit_data[i*NT*XL +: NT*XL] = b.data;
        commit_sop[i]              = s;
        commit_eop[i]              = e;
        cur_b[i]                   = b;
    endtask

    // One cycle: check grant and registered valid mid-cycle, record the expected winner beat.
    task automatic cyc(input logic [N-1:0] exp_rdy, input int win);
        @(negedge clk);
        checks++;
        if (commit_ready !== exp_rdy) begin
            failures++;
            $display("FAIL commit_ready t=%0t got=%b want=%b", $time, commit_ready, exp_rdy);
        end
        checks++;
        if (writeback_valid !== prev_vld) begin
            failures++;
            $display("FAIL writeback_valid t=%0t got=%b want=%b", $time, writeback_valid, prev_vld);
        end
        if (win >= 0) exp_q.push_back(cur_b[win]);
        prev_vld = (win >= 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t act;
        beat_t exp;
        if (writeback_valid === 1'b1) begin
            act.uuid  = writeback_uuid;
            act.wis   = writeback_wis;
            act.tmask = writeback_tmask;
            act.pc    = writeback_PC;
            act.rd    = writeback_rd;
            act.data  = writeback_data;
            act.sop   = writeback_sop;
            act.eop   = writeback_eop;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat t=%0t got rd=%0d wis=%0d", $time, act.rd, act.wis);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL beat t=%0t got rd=%0d wis=%0d sop=%b eop=%b data=%h want rd=%0d wis=%0d sop=%b eop=%b data=%h",
                             $time, act.rd, act.wis, act.sop, act.eop, act.data,
                             exp.rd, exp.wis, exp.sop, exp.eop, exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        commit_valid = '0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 6'(5 + i), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        // Reset with all inputs valid
        cyc(3'b000, -1);
        cyc(3'b000, -1);
        checks++;
        if ({writeback_uuid, writeback_wis, writeback_tmask, writeback_PC, writeback_rd,
             writeback_data, writeback_sop, writeback_eop} !== '0) begin
            failures++;
            $display("FAIL reset_fields got rd=%0d data=%h want all zero", writeback_rd, writeback_data);
        end
        reset = 1'b0;

        // Round robin over single-beat packets: rd 5,6,7,5
        cyc(3'b001, 0);
        cyc(3'b010, 1);
        cyc(3'b100, 2);
        cyc(3'b001, 0);

        // Input 1 three-beat packet locks out input 0; pointer then moves to 2
        set_in(0, 1'b1, 6'd8, 1'b1, 1'b1);
        set_in(1, 1'b1, 6'd10, 1'b1, 1'b0);
        set_in(2, 1'b0, 6'd7, 1'b1, 1'b1);
        cyc(3'b010, 1);
        set_in(1, 1'b1, 6'd11, 1'b0, 1'b0);
        cyc(3'b010, 1);
        set_in(1, 1'b1, 6'd12, 1'b0, 1'b1);
        cyc(3'b010, 1);
        set_in(1, 1'b1, 6'd13, 1'b1, 1'b1);
        cyc(3'b001, 0);
        set_in(0, 1'b0, 6'd8, 1'b1, 1'b1);
        cyc(3'b010, 1);

        // Owner bubble: input 2 locked, drops valid for 2 cycles while input 0 waits
        set_in(0, 1'b1, 6'd9, 1'b1, 1'b1);
        set_in(1, 1'b0, 6'd13, 1'b1, 1'b1);
        set_in(2, 1'b1, 6'd20, 1'b1, 1'b0);
        cyc(3'b100, 2);
        set_in(2, 1'b0, 6'd21, 1'b0, 1'b1);
        cyc(3'b000, -1);
        cyc(3'b000, -1);
        set_in(2, 1'b1, 6'd21, 1'b1, 1'b1);
        cyc(3'b100, 2);
        cyc(3'b001, 0);

        // Reset in the middle of an input-1 packet
        set_in(0, 1'b0, 6'd9, 1'b1, 1'b1);
        set_in(1, 1'b1, 6'd30, 1'b1, 1'b0);
        set_in(2, 1'b0, 6'd21, 1'b1, 1'b1);
        cyc(3'b010, 1);
        reset = 1'b1;
        set_in(0, 1'b1, 6'd40, 1'b1, 1'b1);
        set_in(1, 1'b1, 6'd31, 1'b0, 1'b0);
        cyc(3'b000, -1);
        reset = 1'b0;
        cyc(3'b001, 0);
        set_in(0, 1'b0, 6'd40, 1'b1, 1'b1);
        set_in(1, 1'b1, 6'd32, 1'b0, 1'b1);
        cyc(3'b010, 1);

        // Fresh reset, then 10 cycles of all inputs valid with single-beat packets
        for (int i = 0; i < N; i++) set_in(i, 1'b0, 6'd0, 1'b1, 1'b1);
        reset = 1'b1;
        cyc(3'b000, -1);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 6'(50 + i), 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) cyc(3'(1 << (k % 3)), k % 3);
        for (int i = 0; i < N; i++) set_in(i, 1'b0, 6'(50 + i), 1'b1, 1'b1);
        cyc(3'b000, -1);
`ifdef WB_ARB_PERF_EN
        checks++;
        if (perf_stall_cycles !== 32'd10) begin
            failures++;
            $display("FAIL perf_stall_cycles got=%0d want=10", perf_stall_cycles);
        end
`endif
        cyc(3'b000, -1);
        cyc(3'b000, -1);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
